pipelined_tree_adder: RTL
=========================

PIPELINED_TREE_ADDER -- requirements
Module: pipelined_tree_adder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: width of each input term.
REQ-002 The block SHALL have parameter NUM_TERMS, default 8: number of terms, any value 2..64, not restricted to powers of two.
REQ-003 The block SHALL have parameter SIGNED, default 0: 1 = two's-complement terms (sign-extended), 0 = unsigned (zero-extended).
REQ-004 The block SHALL have parameter PIPE_STRIDE, default 1: adder levels per register stage, range 1..NUM_STAGES.
REQ-005 The block SHALL have parameter NUM_STAGES, default $clog2(NUM_TERMS): number of adder-tree levels.
REQ-006 The block SHALL have parameter OUTPUT_WIDTH, default DATA_WIDTH+NUM_STAGES: result width.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port nreset, input, 1 bit: asynchronous active-low reset.
REQ-009 The block SHALL have port s_valid, input, 1 bit: an input vector is present.
REQ-010 The block SHALL have port s_ready, output, 1 bit: the block accepts the vector this cycle.
REQ-011 The block SHALL have port s_data, input, DATA_WIDTH*NUM_TERMS bits: term k in bits [DATA_WIDTH*k +: DATA_WIDTH].
REQ-012 The block SHALL have port m_valid, output, 1 bit: m_data holds a result.
REQ-013 The block SHALL have port m_ready, input, 1 bit: the downstream consumer takes the result.
REQ-014 The block SHALL have port m_data, output, OUTPUT_WIDTH bits: the sum.

Function
REQ-015 Transfer SHALL occur on s_valid&&s_ready (input) and on m_valid&&m_ready (output).
REQ-016 The tree SHALL pad NUM_TERMS up to 2^NUM_STAGES with zero terms; padding SHALL NOT change the sum.
REQ-017 Each term SHALL be extended to OUTPUT_WIDTH per SIGNED before addition; all adds SHALL be modulo 2^OUTPUT_WIDTH.
REQ-018 A register stage SHALL follow every PIPE_STRIDE adder levels, plus a final stage if NUM_STAGES is not a multiple of PIPE_STRIDE; LATENCY = ceil(NUM_STAGES/PIPE_STRIDE) cycles.
REQ-019 Each register stage SHALL carry one valid bit alongside its data.
REQ-020 Pipeline enable SHALL be en = m_ready || !m_valid; all stages SHALL advance together only when en=1; s_ready SHALL equal en.
REQ-021 When en=0, all stage data and valid bits SHALL hold; m_data SHALL be stable while m_valid=1 and m_ready=0.
REQ-022 Bubbles SHALL propagate as valid=0 stages and SHALL NOT be collapsed.
REQ-023 Results SHALL leave the block in acceptance order, one per accepted vector, none lost or duplicated.
REQ-024 With m_ready held at 1, throughput SHALL be one result per cycle.
REQ-025 If s_valid=1 and s_ready=0 in a cycle, the input SHALL NOT be captured.

Reset
REQ-026 Assertion of nreset SHALL immediately clear all stage valid bits; m_valid SHALL read 0 and s_ready SHALL read 1 during reset.
REQ-027 Data registers SHALL NOT require reset; m_data SHALL be don't-care while m_valid=0.
REQ-028 Reset mid-operation SHALL discard every in-flight result; the first vector after deassertion SHALL emerge after exactly LATENCY enabled cycles.

Configuration
REQ-029 When macro PIPELINED_TREE_ADDER_ACCUM_EN is defined, ports s_last (input, 1 bit) and m_last (output, 1 bit) SHALL exist, and an accumulator stage SHALL follow the tree.
REQ-030 With PIPELINED_TREE_ADDER_ACCUM_EN defined, the accumulator SHALL sum tree results of consecutive beats modulo 2^OUTPUT_WIDTH.
REQ-031 With PIPELINED_TREE_ADDER_ACCUM_EN defined, m_valid SHALL assert only for the beat tagged s_last=1, with m_last=1, and the accumulator SHALL then clear.
REQ-032 With PIPELINED_TREE_ADDER_ACCUM_EN defined, LATENCY SHALL be ceil(NUM_STAGES/PIPE_STRIDE)+1; the accumulator SHALL clear on reset.
REQ-033 Without PIPELINED_TREE_ADDER_ACCUM_EN, s_last, m_last and the accumulator SHALL be absent, and every accepted vector SHALL produce one result.

Verification
REQ-034 Unsigned: NUM_TERMS=8, DATA_WIDTH=16, all terms 0xFFFF, m_ready=1 -> m_data=0x7FFF8 after 3 cycles.
REQ-035 Signed, non-power-of-two: NUM_TERMS=5, SIGNED=1, terms {-1,-2,3,4,-5} -> m_data=-1, with padding verified.
REQ-036 Backpressure: 20 back-to-back random vectors, m_ready toggled pseudo-randomly -> outputs in order, matching the model, m_data stable while stalled.
REQ-037 Latency: PIPE_STRIDE=2, NUM_TERMS=16 (4 levels) -> LATENCY=2; PIPE_STRIDE=3 -> LATENCY=2 (final stage added).
REQ-038 Reset mid-flight: 3 vectors accepted, nreset pulsed low -> m_valid=0 immediately, no stale results after release.
REQ-039 With PIPELINED_TREE_ADDER_ACCUM_EN: 4 beats of all-ones terms (sum 8 each), s_last on beat 4 -> a single result 32 with m_last=1, and the next frame starts from 0.

Source files
------------

// File: rtl/pipelined_tree_adder_if.sv
// Stream interface for pipelined_tree_adder: input vector handshake and result handshake.
// With PIPELINED_TREE_ADDER_ACCUM_EN defined, frame markers s_last/m_last are added.
interface pipelined_tree_adder_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_TERMS    = 8,
    parameter int OUTPUT_WIDTH = 19
);
    logic                             s_valid;
    logic                             s_ready;
    logic [DATA_WIDTH*NUM_TERMS-1:0]  s_data;
    logic                             m_valid;
    logic                             m_ready;
    logic [OUTPUT_WIDTH-1:0]          m_data;
`ifdef PIPELINED_TREE_ADDER_ACCUM_EN
    logic                             s_last;
    logic                             m_last;

    modport master (output s_valid, s_data, s_last, m_ready,
                    input  s_ready, m_valid, m_data, m_last);
    modport slave  (input  s_valid, s_data, s_last, m_ready,
                    output s_ready, m_valid, m_data, m_last);
`else
    modport master (output s_valid, s_data, m_ready,
                    input  s_ready, m_valid, m_data);
    modport slave  (input  s_valid, s_data, m_ready,
                    output s_ready, m_valid, m_data);
`endif
endinterface

// File: rtl/pipelined_tree_adder.sv
// Pipelined binary adder tree summing NUM_TERMS terms, one global stall enable.
// Optional macro PIPELINED_TREE_ADDER_ACCUM_EN appends a frame accumulator stage.
module pipelined_tree_adder #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_TERMS    = 8,
    parameter int SIGNED       = 0,
    parameter int PIPE_STRIDE  = 1,
    parameter int NUM_STAGES   = $clog2(NUM_TERMS),
    parameter int OUTPUT_WIDTH = DATA_WIDTH + NUM_STAGES
) (
    input  logic                  clk,
    input  logic                  nreset,
    pipelined_tree_adder_if.slave bus
);
    localparam int PAD_TERMS = 1 << NUM_STAGES;

    logic                    en;
    logic [OUTPUT_WIDTH-1:0] tree_sum;
    logic                    tree_vld;
`ifdef PIPELINED_TREE_ADDER_ACCUM_EN
    logic                    tree_lst;
`endif

    // Every stage advances together; a held output freezes the whole pipe.
    assign en          = bus.m_ready || !bus.m_valid;
    assign bus.s_ready = en;

    for (genvar l = 0; l <= NUM_STAGES; l++) begin : g_lvl
        localparam int NODES = PAD_TERMS >> l;

        logic [OUTPUT_WIDTH-1:0] node [NODES];
        logic                    vld;
`ifdef PIPELINED_TREE_ADDER_ACCUM_EN
        logic                    lst;
`endif

        if (l == 0) begin : g_leaf
            for (genvar k = 0; k < NODES; k++) begin : g_term
                if (k >= NUM_TERMS) begin : g_pad
                    assign node[k] = '0;
                end else if (SIGNED != 0) begin : g_sext
                    assign node[k] = OUTPUT_WIDTH'($signed(bus.s_data[DATA_WIDTH*k +: DATA_WIDTH]));
                end else begin : g_zext
                    assign node[k] = OUTPUT_WIDTH'(bus.s_data[DATA_WIDTH*k +: DATA_WIDTH]);
                end
            end
            assign vld = bus.s_valid && en;
`ifdef PIPELINED_TREE_ADDER_ACCUM_EN
            assign lst = bus.s_last;
`endif
        end else begin : g_add
            logic [OUTPUT_WIDTH-1:0] sum_d [NODES];

            for (genvar k = 0; k < NODES; k++) begin : g_node
                assign sum_d[k] = g_lvl[l-1].node[2*k] + g_lvl[l-1].node[2*k+1];
            end

            if ((l % PIPE_STRIDE == 0) || (l == NUM_STAGES)) begin : g_reg
                logic [OUTPUT_WIDTH-1:0] sum_q [NODES];
                logic                    vld_q;
`ifdef PIPELINED_TREE_ADDER_ACCUM_EN
                logic                    lst_q;
`endif

                // NOTE: data registers carry no reset; the valid bit qualifies them.
                always_ff @(posedge clk) begin
                    if (en) begin
                        // NOTE: non-blocking so every stage samples pre-edge values.
                        sum_q <= sum_d;
`ifdef PIPELINED_TREE_ADDER_ACCUM_EN
                        lst_q <= g_lvl[l-1].lst;
`endif
                    end
                end

                always_ff @(posedge clk or negedge nreset) begin
                    if (!nreset) begin
                        vld_q <= 1'b0;
                    end else if (en) begin
                        vld_q <= g_lvl[l-1].vld;
                    end
                end

                assign node = sum_q;
                assign vld  = vld_q;
`ifdef PIPELINED_TREE_ADDER_ACCUM_EN
                assign lst  = lst_q;
`endif
            end else begin : g_comb
                assign node = sum_d;
                assign vld  = g_lvl[l-1].vld;
`ifdef PIPELINED_TREE_ADDER_ACCUM_EN
                assign lst  = g_lvl[l-1].lst;
`endif
            end
        end
    end

    assign tree_sum = g_lvl[NUM_STAGES].node[0];
    assign tree_vld = g_lvl[NUM_STAGES].vld;

`ifdef PIPELINED_TREE_ADDER_ACCUM_EN
    assign tree_lst = g_lvl[NUM_STAGES].lst;

    logic [OUTPUT_WIDTH-1:0] acc_d, acc_q, out_d, out_q, total;
    logic                    out_vld_d, out_vld_q;

    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        acc_d     = acc_q;
        out_d     = out_q;
        out_vld_d = out_vld_q;
        total     = acc_q + tree_sum;
        if (en) begin
            out_vld_d = tree_vld && tree_lst;
            if (tree_vld) begin
                if (tree_lst) begin
                    out_d = total;
                    acc_d = '0;
                end else begin
                    acc_d = total;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            acc_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            out_vld_q <= out_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        out_q <= out_d;
    end

    assign bus.m_valid = out_vld_q;
    assign bus.m_last  = out_vld_q;
    assign bus.m_data  = out_q;
`else
    assign bus.m_valid = tree_vld;
    assign bus.m_data  = tree_sum;
`endif
endmodule
